// File: rtl/dma_reg_pkg.sv
// Shared types and constants for the two-requester DMA register-bus arbiter.
// The command struct is sized for 32-bit address/data buses.
package dma_reg_pkg;

    localparam int NUM_REQ    = 2;
    localparam int RD_LAT_MAX = 7;
    localparam int CMD_ADDR_W = 32;
    localparam int CMD_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic                  wr;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
        logic                  idx;
    } reg_cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector.
// The 'last' input holds the index of the most recent winner.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    // On a tie, the requester that did not win last time gets the grant.
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dma_reg_arb.sv
// Shares one register bus between two requesters, one transaction at a time.
// Bus strobes and responses are decoded from registered state, so they are clean pulses.
module dma_reg_arb
    import dma_reg_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_wr,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [ADDR_W-1:0]   addr,
    output logic                wr_en,
    output logic                rd_en,
    output logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   rdata
);

    arb_state_e        state;
    reg_cmd_t          cmd;
    logic [2:0]        lat_cnt;
    logic              last;
    logic              armed;
    logic [DATA_W-1:0] resp_data;
    logic [1:0]        grant;
    logic              grant_fire;
    logic              sel;

    rr_arb2 u_rr_arb2 (
        .valid (req_valid),
        .last  (last),
        .grant (grant)
    );

    // 'armed' holds off grants until the cycle after reset is released.
    assign grant_fire = armed && (state == IDLE) && (|req_valid);
    assign req_ready  = grant_fire ? grant : 2'b00;
    assign sel        = grant[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd       <= '0;
            lat_cnt   <= '0;
            last      <= 1'b1;
            armed     <= 1'b0;
            resp_data <= '0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (grant_fire) begin
                        // Only the winner's fields are looked at.
                        cmd.wr    <= sel ? req_wr[1] : req_wr[0];
                        cmd.addr  <= CMD_ADDR_W'(sel ? req_addr[2*ADDR_W-1:ADDR_W]
                                                     : req_addr[ADDR_W-1:0]);
                        cmd.wdata <= CMD_DATA_W'(sel ? req_wdata[2*DATA_W-1:DATA_W]
                                                     : req_wdata[DATA_W-1:0]);
                        cmd.idx   <= sel;
                        last      <= sel;
                        resp_data <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    lat_cnt <= '0;
                    state   <= cmd.wr ? RESP : WAIT_RD;
                end
                WAIT_RD: begin
                    if (lat_cnt == 3'(RD_LAT - 1)) begin
                        resp_data <= rdata;
                        lat_cnt   <= '0;
                        state     <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign addr      = (state == ISSUE) ? ADDR_W'(cmd.addr) : '0;
    assign wdata     = (state == ISSUE) ? DATA_W'(cmd.wdata) : '0;
    assign wr_en     = (state == ISSUE) && cmd.wr;
    assign rd_en     = (state == ISSUE) && !cmd.wr;
    assign rsp_valid = (state == RESP) ? (cmd.idx ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata = (state == RESP) ? resp_data : '0;

endmodule

// File: tb/tb_dma_reg_arb.sv
// Directed bench for dma_reg_arb with three instances (RD_LAT = 1, 3, 7).
// Each bus model returns valid data only on the exact expected cycle.
module tb_dma_reg_arb;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid, req_wr;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [DW-1:0] bus_value;
    int            errors = 0;
    int            checks = 0;

    logic [1:0]    r1_req_ready, r1_rsp_valid, r3_req_ready, r3_rsp_valid, r7_req_ready, r7_rsp_valid;
    logic [DW-1:0] r1_rsp_rdata, r1_wdata, r1_rdata, r3_rsp_rdata, r3_wdata, r3_rdata;
    logic [DW-1:0] r7_rsp_rdata, r7_wdata, r7_rdata;
    logic [AW-1:0] r1_addr, r3_addr, r7_addr;
    logic          r1_wr_en, r1_rd_en, r3_wr_en, r3_rd_en, r7_wr_en, r7_rd_en;
    int            cnt1 = 0, cnt3 = 0, cnt7 = 0;

    always #5 clk = ~clk;

    dma_reg_arb #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(r1_req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(r1_rsp_valid), .rsp_rdata(r1_rsp_rdata), .addr(r1_addr),
        .wr_en(r1_wr_en), .rd_en(r1_rd_en), .wdata(r1_wdata), .rdata(r1_rdata));

    dma_reg_arb #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(r3_req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(r3_rsp_valid), .rsp_rdata(r3_rsp_rdata), .addr(r3_addr),
        .wr_en(r3_wr_en), .rd_en(r3_rd_en), .wdata(r3_wdata), .rdata(r3_rdata));

    dma_reg_arb #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(r7_req_ready),
        .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(r7_rsp_valid), .rsp_rdata(r7_rsp_rdata), .addr(r7_addr),
        .wr_en(r7_wr_en), .rd_en(r7_rd_en), .wdata(r7_wdata), .rdata(r7_rdata));

    // Bus models: data is valid only in the single cycle RD_LAT after the rd_en edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            cnt1 <= 0; cnt3 <= 0; cnt7 <= 0;
        end else begin
            cnt1 <= r1_rd_en ? 1 : ((cnt1 > 0) ? cnt1 - 1 : 0);
            cnt3 <= r3_rd_en ? 3 : ((cnt3 > 0) ? cnt3 - 1 : 0);
            cnt7 <= r7_rd_en ? 7 : ((cnt7 > 0) ? cnt7 - 1 : 0);
        end
    end
    assign r1_rdata = (cnt1 == 1) ? bus_value : ~bus_value;
    assign r3_rdata = (cnt3 == 1) ? bus_value : ~bus_value;
    assign r7_rdata = (cnt7 == 1) ? bus_value : ~bus_value;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic at_sample;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0; req_valid = 2'b00; req_wr = 2'b00; req_addr = '0; req_wdata = '0;
        repeat (2) next_cycle;
        rst_n = 1'b1;
        next_cycle;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 2'b11; req_wr = 2'b01;
        req_addr = {32'h0000_0200, 32'h0000_0100}; req_wdata = {32'h2222_2222, 32'h1111_1111};
        repeat (2) next_cycle;
        at_sample;
        checks++; if (r1_req_ready !== 2'b00) begin errors++; $display("[TB] FAIL rst_req_ready: got %b expected 00", r1_req_ready); end
        checks++; if (r1_rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL rst_rsp_valid: got %b expected 00", r1_rsp_valid); end
        checks++; if ({r1_wr_en, r1_rd_en} !== 2'b00) begin errors++; $display("[TB] FAIL rst_strobes: got %b expected 00", {r1_wr_en, r1_rd_en}); end
        checks++; if (r1_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_addr: got %h expected 0", r1_addr); end
        checks++; if (r1_wdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_wdata: got %h expected 0", r1_wdata); end
        checks++; if (r1_rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_rsp_rdata: got %h expected 0", r1_rsp_rdata); end
        checks++; if (r7_req_ready !== 2'b00) begin errors++; $display("[TB] FAIL rst_req_ready7: got %b expected 00", r7_req_ready); end
        next_cycle;
        rst_n = 1'b1;
        at_sample;
        checks++; if (r1_req_ready !== 2'b00) begin errors++; $display("[TB] FAIL release_no_grant: got %b expected 00", r1_req_ready); end
        next_cycle;
        at_sample;
        checks++; if (r1_req_ready !== 2'b01) begin errors++; $display("[TB] FAIL first_tie_grant: got %b expected 01", r1_req_ready); end
        next_cycle;
        req_valid = 2'b00;
        repeat (12) next_cycle;
    endtask

    task automatic test_write;
        do_reset;
        req_valid = 2'b01; req_wr = 2'b01;
        req_addr = {32'hFFFF_FFF0, 32'h0000_0010}; req_wdata = {32'h5555_5555, 32'hDEAD_BEEF};
        at_sample;
        checks++; if (r1_req_ready !== 2'b01) begin errors++; $display("[TB] FAIL wr_ready: got %b expected 01", r1_req_ready); end
        next_cycle;
        req_valid = 2'b00;
        at_sample;
        checks++; if ({r1_wr_en, r1_rd_en} !== 2'b10) begin errors++; $display("[TB] FAIL wr_strobe: got %b expected 10", {r1_wr_en, r1_rd_en}); end
        checks++; if (r1_addr !== 32'h0000_0010) begin errors++; $display("[TB] FAIL wr_addr: got %h expected 00000010", r1_addr); end
        checks++; if (r1_wdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL wr_wdata: got %h expected deadbeef", r1_wdata); end
        checks++; if (r1_rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL wr_early_rsp: got %b expected 00", r1_rsp_valid); end
        next_cycle;
        at_sample;
        checks++; if (r1_rsp_valid !== 2'b01) begin errors++; $display("[TB] FAIL wr_rsp_valid: got %b expected 01", r1_rsp_valid); end
        checks++; if (r1_rsp_rdata !== 32'h0) begin errors++; $display("[TB] FAIL wr_rsp_rdata: got %h expected 0", r1_rsp_rdata); end
        checks++; if ({r1_wr_en, r1_addr} !== 33'h0) begin errors++; $display("[TB] FAIL wr_bus_idle: got %h expected 0", {r1_wr_en, r1_addr}); end
        next_cycle;
        at_sample;
        checks++; if (r1_rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL wr_rsp_pulse: got %b expected 00", r1_rsp_valid); end
    endtask

    task automatic test_read;
        do_reset;
        bus_value = 32'h1234_5678;
        req_valid = 2'b10; req_wr = 2'b00;
        req_addr = {32'h0000_0014, 32'h0000_0000}; req_wdata = '0;
        at_sample;
        checks++; if (r1_req_ready !== 2'b10) begin errors++; $display("[TB] FAIL rd_ready: got %b expected 10", r1_req_ready); end
        next_cycle;
        req_valid = 2'b00;
        at_sample;
        checks++; if ({r1_wr_en, r1_rd_en} !== 2'b01) begin errors++; $display("[TB] FAIL rd_strobe: got %b expected 01", {r1_wr_en, r1_rd_en}); end
        checks++; if (r1_addr !== 32'h0000_0014) begin errors++; $display("[TB] FAIL rd_addr: got %h expected 00000014", r1_addr); end
        next_cycle;
        at_sample;
        checks++; if ({r1_rd_en, r1_rsp_valid} !== 3'b000) begin errors++; $display("[TB] FAIL rd_wait: got %b expected 000", {r1_rd_en, r1_rsp_valid}); end
        next_cycle;
        at_sample;
        checks++; if (r1_rsp_valid !== 2'b10) begin errors++; $display("[TB] FAIL rd_rsp_valid: got %b expected 10", r1_rsp_valid); end
        checks++; if (r1_rsp_rdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL rd_rsp_rdata: got %h expected 12345678", r1_rsp_rdata); end
        next_cycle;
        at_sample;
        checks++; if ({r1_rsp_valid, r1_rsp_rdata} !== 34'h0) begin errors++; $display("[TB] FAIL rd_rsp_end: got %h expected 0", {r1_rsp_valid, r1_rsp_rdata}); end
    endtask

    task automatic test_read_lat7;
        do_reset;
        bus_value = 32'hCAFE_0007;
        req_valid = 2'b01; req_wr = 2'b00;
        req_addr = {32'h0000_0000, 32'h0000_0020}; req_wdata = '0;
        at_sample;
        checks++; if (r7_req_ready !== 2'b01) begin errors++; $display("[TB] FAIL lat7_ready: got %b expected 01", r7_req_ready); end
        next_cycle;
        req_valid = 2'b00;
        at_sample;
        checks++; if (r7_rd_en !== 1'b1) begin errors++; $display("[TB] FAIL lat7_rd_en: got %b expected 1", r7_rd_en); end
        for (int c = 3; c <= 9; c++) begin
            next_cycle;
            at_sample;
            checks++; if (r7_rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL lat7_early_rsp: cycle %0d got %b expected 00", c, r7_rsp_valid); end
            if (c == 6) begin
                checks++; if (r3_rsp_valid !== 2'b01) begin errors++; $display("[TB] FAIL lat3_rsp_valid: got %b expected 01", r3_rsp_valid); end
                checks++; if (r3_rsp_rdata !== 32'hCAFE_0007) begin errors++; $display("[TB] FAIL lat3_rsp_rdata: got %h expected cafe0007", r3_rsp_rdata); end
            end
        end
        next_cycle;
        at_sample;
        checks++; if (r7_rsp_valid !== 2'b01) begin errors++; $display("[TB] FAIL lat7_rsp_valid: got %b expected 01", r7_rsp_valid); end
        checks++; if (r7_rsp_rdata !== 32'hCAFE_0007) begin errors++; $display("[TB] FAIL lat7_rsp_rdata: got %h expected cafe0007", r7_rsp_rdata); end
    endtask

    task automatic test_round_robin;
        int grants[$];
        int cyc;
        int exp_order[4];
        logic [AW-1:0] exp_addr;
        exp_order = '{0, 1, 0, 1};
        cyc = 0;
        do_reset;
        req_valid = 2'b11; req_wr = 2'b11;
        req_addr = {32'h0000_0200, 32'h0000_0100}; req_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
        while (grants.size() < 4 && cyc < 40) begin
            at_sample;
            if (r1_req_ready != 2'b00) grants.push_back((r1_req_ready == 2'b10) ? 1 : 0);
            checks++; if ((r1_wr_en & r1_rd_en) !== 1'b0) begin errors++; $display("[TB] FAIL rr_strobe_overlap: got 1 expected 0"); end
            if (r1_wr_en && grants.size() > 0) begin
                exp_addr = (grants[grants.size()-1] == 1) ? 32'h0000_0200 : 32'h0000_0100;
                checks++; if (r1_addr !== exp_addr) begin errors++; $display("[TB] FAIL rr_addr: got %h expected %h", r1_addr, exp_addr); end
            end
            next_cycle;
            cyc++;
        end
        req_valid = 2'b00;
        checks++; if (grants.size() != 4) begin errors++; $display("[TB] FAIL rr_grant_count: got %0d expected 4", grants.size()); end
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            checks++; if (grants[i] !== exp_order[i]) begin errors++; $display("[TB] FAIL rr_order[%0d]: got %0d expected %0d", i, grants[i], exp_order[i]); end
        end
        repeat (4) next_cycle;
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] wd[3];
        int gcyc[3];
        int k, rsp, cyc;
        logic granted;
        wd = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003};
        k = 0; rsp = 0; cyc = 1;
        do_reset;
        req_valid = 2'b10; req_wr = 2'b10;
        req_addr = {32'h0000_0040, 32'h0000_0000}; req_wdata = {wd[0], 32'h0};
        while (rsp < 3 && cyc < 40) begin
            at_sample;
            granted = 1'b0;
            if (r1_req_ready != 2'b00) begin
                checks++; if (r1_req_ready !== 2'b10) begin errors++; $display("[TB] FAIL b2b_grant: got %b expected 10", r1_req_ready); end
                if (k < 3) gcyc[k] = cyc;
                k++;
                granted = 1'b1;
            end
            if (r1_wr_en && k >= 1 && k <= 3) begin
                checks++; if (r1_wdata !== wd[k-1]) begin errors++; $display("[TB] FAIL b2b_wdata: got %h expected %h", r1_wdata, wd[k-1]); end
            end
            if (r1_rsp_valid != 2'b00 && rsp < 3) begin
                checks++; if (r1_rsp_valid !== 2'b10) begin errors++; $display("[TB] FAIL b2b_rsp_valid: got %b expected 10", r1_rsp_valid); end
                checks++; if (cyc !== gcyc[rsp] + 2) begin errors++; $display("[TB] FAIL b2b_latency: got cycle %0d expected %0d", cyc, gcyc[rsp] + 2); end
                rsp++;
            end
            next_cycle;
            cyc++;
            if (granted) begin
                if (k < 3) req_wdata = {wd[k], 32'h0};
                else req_valid = 2'b00;
            end
        end
        req_valid = 2'b00;
        checks++; if (rsp != 3 || k != 3) begin errors++; $display("[TB] FAIL b2b_count: got grants=%0d rsps=%0d expected 3 and 3", k, rsp); end
        repeat (2) next_cycle;
    endtask

    task automatic test_reset_abort;
        do_reset;
        bus_value = 32'h0BAD_0030;
        req_valid = 2'b01; req_wr = 2'b00;
        req_addr = {32'h0000_0000, 32'h0000_0030}; req_wdata = '0;
        at_sample;
        checks++; if (r3_req_ready !== 2'b01) begin errors++; $display("[TB] FAIL abort_ready: got %b expected 01", r3_req_ready); end
        next_cycle;
        req_valid = 2'b00;
        at_sample;
        checks++; if (r3_rd_en !== 1'b1) begin errors++; $display("[TB] FAIL abort_rd_en: got %b expected 1", r3_rd_en); end
        next_cycle;
        next_cycle;
        rst_n = 1'b0;
        next_cycle;
        at_sample;
        checks++; if (r3_rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL abort_rsp_valid: got %b expected 00", r3_rsp_valid); end
        checks++; if ({r3_wr_en, r3_rd_en, r3_addr, r3_wdata, r3_rsp_rdata} !== 98'h0) begin
            errors++; $display("[TB] FAIL abort_outputs: got %h expected 0", {r3_wr_en, r3_rd_en, r3_addr, r3_wdata, r3_rsp_rdata});
        end
        next_cycle;
        rst_n = 1'b1; req_valid = 2'b11; req_wr = 2'b11;
        req_addr = {32'h0000_0034, 32'h0000_0030}; req_wdata = {32'h2, 32'h1};
        at_sample;
        checks++; if ({r3_req_ready, r3_rsp_valid} !== 4'b0000) begin errors++; $display("[TB] FAIL abort_release: got %b expected 0000", {r3_req_ready, r3_rsp_valid}); end
        next_cycle;
        at_sample;
        checks++; if (r3_req_ready !== 2'b01) begin errors++; $display("[TB] FAIL abort_tie_grant: got %b expected 01", r3_req_ready); end
        checks++; if (r3_rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL abort_no_rsp: got %b expected 00", r3_rsp_valid); end
        next_cycle;
        req_valid = 2'b00;
        repeat (4) next_cycle;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 2'b00; req_wr = 2'b00;
        req_addr = '0; req_wdata = '0; bus_value = 32'h0;
        test_reset;
        test_write;
        test_read;
        test_read_lat7;
        test_round_robin;
        test_back_to_back;
        test_reset_abort;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dma_reg_arb.md
DMA_REG_ARB -- requirements
Module: dma_reg_arb

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_W, 32, register address width.
- DATA_W, 32, register data width.
- RD_LAT, 1, cycles from rd_en sample edge to valid rdata; legal range 1..7.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on posedge.
- rst_n, in, 1, reset, synchronous, active-low.
- req_valid, in, 2, per-requester command valid.
- req_ready, out, 2, per-requester command accepted (one-hot or zero).
- req_wr, in, 2, per-requester write (1) / read (0).
- req_addr, in, 2xADDR_W, per-requester address.
- req_wdata, in, 2xDATA_W, per-requester write data.
- rsp_valid, out, 2, per-requester completion pulse.
- rsp_rdata, out, DATA_W, read data for the completing requester (shared).
- addr, out, ADDR_W, register bus address.
- wr_en, out, 1, register bus write strobe.
- rd_en, out, 1, register bus read strobe.
- wdata, out, DATA_W, register bus write data.
- rdata, in, DATA_W, register bus read data.

Function
REQ-003 The block shall share one DMA register bus between requesters 0 and 1, with at most one transaction outstanding.
REQ-004 The FSM shall have states IDLE, ISSUE, WAIT_RD, RESP.
REQ-005 In IDLE with any req_valid high, the block shall pulse req_ready for the winner for one cycle, capture its wr, addr, wdata and index, and go to ISSUE.
REQ-006 Arbitration shall be round-robin: with both requesting, the requester not granted last shall win; with one requesting, it shall win regardless of pointer.
REQ-007 The last-grant pointer shall update only on a req_ready pulse.
REQ-008 In ISSUE, the block shall drive addr/wdata from the captured command and assert exactly one of wr_en or rd_en for exactly one cycle.
- Write: next state RESP.
- Read: next state WAIT_RD.
REQ-009 WAIT_RD shall count RD_LAT cycles after the ISSUE cycle, sample rdata on the final count into a response register, then go to RESP.
REQ-010 In RESP, the block shall pulse rsp_valid for the captured index only, for one cycle.
- rsp_rdata carries read data; zero for writes.
- Next state IDLE.
REQ-011 No backpressure on responses: requesters shall accept rsp_valid unconditionally.
REQ-012 Requester handshake: req_valid with its fields held stable until req_ready. The block shall not sample the fields of a non-granted requester.
REQ-013 wr_en and rd_en shall never be high together. Both shall be low outside ISSUE.
REQ-014 addr and wdata shall be zero outside ISSUE.
REQ-015 Latency, req_valid high in IDLE to rsp_valid:
- Write: 3 cycles.
- Read: 3+RD_LAT cycles.
- No new grant before returning to IDLE.
REQ-016 req_valid deasserting in ISSUE, WAIT_RD or RESP shall not affect the transaction in progress.

Reset
REQ-017 While rst_n is low at a clock edge, the block shall go to IDLE.
- req_ready, rsp_valid, wr_en, rd_en = 0; addr, wdata, rsp_rdata = 0.
- Latency counter = 0; pointer set so requester 0 wins the first tie.
REQ-018 Reset mid-transaction shall abort it with no rsp_valid. The first grant after rst_n rises shall be no earlier than the cycle following release.

Structure
REQ-019 A shared package dma_reg_pkg shall hold:
- fsm state enum arb_state_e;
- command struct reg_cmd_t {wr, addr, wdata, idx};
- constants NUM_REQ=2 and RD_LAT_MAX=7.
REQ-020 Round-robin selection shall be a sub-module rr_arb2 (inputs: valid[1:0], last; outputs: grant one-hot). The FSM, datapath and counter shall stay in dma_reg_arb.

Verification
REQ-021 Write from requester 0, addr=0x10, wdata=0xDEAD_BEEF -> wr_en high one cycle with those values; rsp_valid[0] 3 cycles after req_valid; rsp_rdata=0.
REQ-022 Read from requester 1, addr=0x14, RD_LAT=1, bus model returns 0x1234_5678 -> rd_en one cycle; rsp_valid[1] at cycle 4 with rsp_rdata=0x1234_5678.
REQ-023 Both requesters hold req_valid continuously for 4 transactions after reset -> grant order 0,1,0,1; no overlapping bus strobes.
REQ-024 Only requester 1 requests, 3 back-to-back writes -> all granted to 1; each rsp_valid[1] 3 cycles after its grant cycle's IDLE.
REQ-025 rst_n asserted during WAIT_RD of a read with RD_LAT=3 -> no rsp_valid; all outputs zero next cycle; next tie grants requester 0.
REQ-026 RD_LAT=7 read -> rdata sampled exactly 7 cycles after the rd_en cycle; value sampled one cycle early or late is rejected by the scoreboard.
